logic_gate_checker: RTL and testbench
=====================================

// Module: logic_gate_checker
// PURPOSE
//  Built-in self-test driver and checker for the seven-output two-input gate block (and, or, not, nand, nor, xor, xnor).
//  Drives a and b into the gate block through all four input combinations.
//  Samples the gate outputs, compares them against a golden model and reports pass/fail with a per-gate failure mask.
//  Sits beside the gate block in test/bring-up top levels. It is the stimulus/response end of that block's interface.
// PARAMETERS
//  SETTLE_CYCLES  2  cycles each vector is held before sampling; legal range >= 1
//  REPEAT         1  number of full 4-vector sweeps per run; legal range >= 1
//  ERR_W          8  width of err_count
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous assert, active-low reset
//  start      in   1      1-cycle run request; ignored unless state is IDLE
//  a_o        out  1      drives gate block input a
//  b_o        out  1      drives gate block input b
//  dut_out    in   7      gate outputs: [0]and [1]or [2]not [3]nand [4]nor [5]xor [6]xnor
//  busy       out  1      high in every state except IDLE
//  done       out  1      1-cycle pulse at end of run
//  pass       out  1      1 when last run had err_count==0; held until next start
//  fail_mask  out  7      OR of mismatch bits over the run; held until next start
//  err_count  out  ERR_W  number of mismatching vectors (saturates at all-ones)
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, vector counter 0, sweep counter 0.
//  FSM states:
//   IDLE: start=1 -> SETTLE with vec=0. Clears fail_mask, err_count and pass.
//   SETTLE: a_o=vec[1], b_o=vec[0] (registered). Stays SETTLE_CYCLES cycles -> CHECK.
//   CHECK: samples dut_out and computes mm = dut_out ^ golden(vec).
//    - fail_mask |= mm.
//    - err_count +1 if mm!=0, saturating.
//    - If vec<3: vec+1 -> SETTLE.
//    - Else if sweep<REPEAT-1: vec=0, sweep+1 -> SETTLE.
//    - Else -> DONE.
//   DONE: done=1 and pass=(err_count==0, including the final CHECK update) for one cycle -> IDLE.
//    a_o/b_o return to 0 in IDLE and DONE.
//  Latency: start sampled at edge 0 -> done high in cycle 4*REPEAT*(SETTLE_CYCLES+1)+1. Defaults give 13.
//  Golden model: and=a&b, or=a|b, not=~a, nand=~(a&b), nor=~(a|b), xor=a^b, xnor=~(a^b).
//  Boundaries:
//   - start while busy or in DONE: ignored, no restart.
//   - X/Z on dut_out counts as a mismatch.
//   - Saturation: err_count holds at 2^ERR_W-1; pass stays 0.
//   - rst_n low mid-run: immediate return to reset values. No done pulse.
// CONFIGURATION
//  CHK_FIRST_FAIL_CAPTURE_EN defined: adds outputs first_fail_vec[1:0], first_fail_sweep[7:0] and first_fail_valid.
//   They capture vec/sweep of the first mismatching CHECK in the run.
//   They are cleared on start and on reset, and held otherwise.
//  CHK_FIRST_FAIL_CAPTURE_EN undefined: these ports and registers do not exist. All other behaviour is identical.
// STRUCTURE
//  Package logic_gate_chk_pkg:
//   - state enum {IDLE, SETTLE, CHECK, DONE}
//   - gate index constants GATE_AND..GATE_XNOR (0..6)
//   - NUM_GATES=7
//  Sub-module gate_golden_model: combinational, inputs a and b, output exp[6:0] in the bit order above.
//  Top level holds the FSM, settle counter, vector counter, sweep counter and result registers.
// TESTING
//  1 Reset then idle: rst_n=0 -> all outputs 0; busy=0 with start held 0 for 20 cycles.
//  2 Correct gate block, defaults, start pulse:
//     - a_o/b_o step 00,01,10,11 with 3 cycles each.
//     - done in cycle 13; pass=1, fail_mask=0, err_count=0.
//  3 xor output stuck-at-0:
//     - Mismatch at vectors 01 and 10.
//     - err_count=2, fail_mask=7'b0100000, pass=0.
//     - With CHK_FIRST_FAIL_CAPTURE_EN: first_fail_vec=2'b01, first_fail_sweep=0.
//  4 REPEAT=3, SETTLE_CYCLES=1, not output inverted:
//     - Done in cycle 25; err_count=12, fail_mask=7'b0000100.
//     - ERR_W=3 variant: err_count saturates at 7.
//  5 start re-pulsed mid-run and during DONE: no restart, timing unchanged.
//     Then start in IDLE: results cleared and new run begins.
//  6 rst_n low in the SETTLE of vector 10: outputs 0 immediately, no done pulse.
//     After release, a fresh start yields done at cycle 13.

Source files
------------

// File: rtl/logic_gate_chk_pkg.sv
// rtl/logic_gate_chk_pkg.sv - shared types and gate indices for the gate-block checker.
package logic_gate_chk_pkg;

   localparam int NUM_GATES = 7;

   localparam int GATE_AND  = 0;
   localparam int GATE_OR   = 1;
   localparam int GATE_NOT  = 2;
   localparam int GATE_NAND = 3;
   localparam int GATE_NOR  = 4;
   localparam int GATE_XOR  = 5;
   localparam int GATE_XNOR = 6;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      CHECK  = 2'd2,
      DONE   = 2'd3
   } chk_state_t;

endpackage

// File: rtl/logic_gate_checker_if.sv
// rtl/logic_gate_checker_if.sv - checker <-> gate block / controller bus.
// CHK_FIRST_FAIL_CAPTURE_EN adds the first-failure capture signals.
interface logic_gate_checker_if
   import logic_gate_chk_pkg::*;
#(
   parameter int ERR_W = 8
);

   logic                 start;
   logic                 a_o;
   logic                 b_o;
   logic [NUM_GATES-1:0] dut_out;
   logic                 busy;
   logic                 done;
   logic                 pass;
   logic [NUM_GATES-1:0] fail_mask;
   logic [ERR_W-1:0]     err_count;
`ifdef CHK_FIRST_FAIL_CAPTURE_EN
   logic [1:0]           first_fail_vec;
   logic [7:0]           first_fail_sweep;
   logic                 first_fail_valid;
`endif

   modport master (
      input  start,
      input  dut_out,
`ifdef CHK_FIRST_FAIL_CAPTURE_EN
      output first_fail_vec,
      output first_fail_sweep,
      output first_fail_valid,
`endif
      output a_o,
      output b_o,
      output busy,
      output done,
      output pass,
      output fail_mask,
      output err_count
   );

   modport slave (
      output start,
      output dut_out,
`ifdef CHK_FIRST_FAIL_CAPTURE_EN
      input  first_fail_vec,
      input  first_fail_sweep,
      input  first_fail_valid,
`endif
      input  a_o,
      input  b_o,
      input  busy,
      input  done,
      input  pass,
      input  fail_mask,
      input  err_count
   );

endinterface

// File: rtl/gate_golden_model.sv
// rtl/gate_golden_model.sv - expected outputs of the seven two-input gates.
module gate_golden_model
   import logic_gate_chk_pkg::*;
(
   input  logic                 a,
   input  logic                 b,
   output logic [NUM_GATES-1:0] exp
);

   always_comb begin
      exp            = '0;
      exp[GATE_AND]  = a & b;
      exp[GATE_OR]   = a | b;
      exp[GATE_NOT]  = ~a;
      exp[GATE_NAND] = ~(a & b);
      exp[GATE_NOR]  = ~(a | b);
      exp[GATE_XOR]  = a ^ b;
      exp[GATE_XNOR] = ~(a ^ b);
   end

endmodule

// File: rtl/logic_gate_checker.sv
// rtl/logic_gate_checker.sv - BIST sweep of a/b into the gate block with per-gate scoring.
// Optional first-failure capture: define CHK_FIRST_FAIL_CAPTURE_EN.
module logic_gate_checker
   import logic_gate_chk_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2,
   parameter int REPEAT        = 1,
   parameter int ERR_W         = 8
) (
   input logic                  clk,
   input logic                  rst_n,
   logic_gate_checker_if.master bus
);

   localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam int SWP_W = (REPEAT > 1) ? $clog2(REPEAT) : 1;

   chk_state_t           r_state;
   logic [SET_W-1:0]     r_settle;
   logic [1:0]           r_vec;
   logic [SWP_W-1:0]     r_sweep;
   logic                 r_a;
   logic                 r_b;
   logic                 r_busy;
   logic                 r_done;
   logic                 r_pass;
   logic [NUM_GATES-1:0] r_fail_mask;
   logic [ERR_W-1:0]     r_err_count;
`ifdef CHK_FIRST_FAIL_CAPTURE_EN
   logic [1:0]           r_ff_vec;
   logic [7:0]           r_ff_sweep;
   logic                 r_ff_valid;
`endif

   logic [NUM_GATES-1:0] w_exp;
   logic [NUM_GATES-1:0] w_mm;
   logic                 w_mismatch;
   logic                 w_last_settle;
   logic                 w_last_sweep;
   logic [1:0]           w_vec_nxt;
   logic [ERR_W-1:0]     w_err_nxt;

   gate_golden_model u_golden (
      .a   (r_vec[1]),
      .b   (r_vec[0]),
      .exp (w_exp)
   );

   // Case equality so that an X/Z from the gate block scores as a mismatch.
   always_comb begin
      w_mm = '0;
      for (int i = 0; i < NUM_GATES; i++) begin
         w_mm[i] = (bus.dut_out[i] === w_exp[i]) ? 1'b0 : 1'b1;
      end
      w_mismatch    = |w_mm;
      w_last_settle = (int'(r_settle) == SETTLE_CYCLES - 1);
      w_last_sweep  = (int'(r_sweep) >= REPEAT - 1);
      w_vec_nxt     = r_vec + 2'd1;
      w_err_nxt     = (w_mismatch && (r_err_count != {ERR_W{1'b1}}))
                      ? r_err_count + ERR_W'(1) : r_err_count;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_settle    <= '0;
         r_vec       <= '0;
         r_sweep     <= '0;
         r_a         <= 1'b0;
         r_b         <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_pass      <= 1'b0;
         r_fail_mask <= '0;
         r_err_count <= '0;
`ifdef CHK_FIRST_FAIL_CAPTURE_EN
         r_ff_vec    <= '0;
         r_ff_sweep  <= '0;
         r_ff_valid  <= 1'b0;
`endif
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.start) begin
                  r_state     <= SETTLE;
                  r_settle    <= '0;
                  r_vec       <= '0;
                  r_sweep     <= '0;
                  r_a         <= 1'b0;
                  r_b         <= 1'b0;
                  r_busy      <= 1'b1;
                  r_pass      <= 1'b0;
                  r_fail_mask <= '0;
                  r_err_count <= '0;
`ifdef CHK_FIRST_FAIL_CAPTURE_EN
                  r_ff_vec    <= '0;
                  r_ff_sweep  <= '0;
                  r_ff_valid  <= 1'b0;
`endif
               end
            end
            SETTLE: begin
               if (w_last_settle) begin
                  r_settle <= '0;
                  r_state  <= CHECK;
               end else begin
                  r_settle <= r_settle + SET_W'(1);
               end
            end
            CHECK: begin
               r_fail_mask <= r_fail_mask | w_mm;
               r_err_count <= w_err_nxt;
`ifdef CHK_FIRST_FAIL_CAPTURE_EN
               if (w_mismatch && !r_ff_valid) begin
                  r_ff_vec   <= r_vec;
                  r_ff_sweep <= 8'(r_sweep);
                  r_ff_valid <= 1'b1;
               end
`endif
               if (r_vec != 2'd3) begin
                  r_vec   <= w_vec_nxt;
                  r_a     <= w_vec_nxt[1];
                  r_b     <= w_vec_nxt[0];
                  r_state <= SETTLE;
               end else if (!w_last_sweep) begin
                  r_vec   <= '0;
                  r_sweep <= r_sweep + SWP_W'(1);
                  r_a     <= 1'b0;
                  r_b     <= 1'b0;
                  r_state <= SETTLE;
               end else begin
                  // pass must reflect this final CHECK, hence w_err_nxt.
                  r_a     <= 1'b0;
                  r_b     <= 1'b0;
                  r_done  <= 1'b1;
                  r_pass  <= (w_err_nxt == '0);
                  r_state <= DONE;
               end
            end
            DONE: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign bus.a_o       = r_a;
   assign bus.b_o       = r_b;
   assign bus.busy      = r_busy;
   assign bus.done      = r_done;
   assign bus.pass      = r_pass;
   assign bus.fail_mask = r_fail_mask;
   assign bus.err_count = r_err_count;
`ifdef CHK_FIRST_FAIL_CAPTURE_EN
   assign bus.first_fail_vec   = r_ff_vec;
   assign bus.first_fail_sweep = r_ff_sweep;
   assign bus.first_fail_valid = r_ff_valid;
`endif

endmodule

// File: tb/tb_logic_gate_checker.sv
// tb/tb_logic_gate_checker.sv - self-checking bench for logic_gate_checker (three configurations).
module tb_logic_gate_checker;

   logic clk;
   logic rst_n;
   logic       st   [3];
   logic [6:0] sa0  [3];
   logic [6:0] flip [3];

   int n_tests = 0;
   int n_fail  = 0;

   logic        obs_a    [3];
   logic        obs_b    [3];
   logic        obs_busy [3];
   logic        obs_done [3];
   logic        obs_pass [3];
   logic [6:0]  obs_mask [3];
   logic [31:0] obs_err  [3];

   logic_gate_checker_if #(.ERR_W(8)) if0 ();
   logic_gate_checker_if #(.ERR_W(8)) if1 ();
   logic_gate_checker_if #(.ERR_W(3)) if2 ();

   logic_gate_checker #(.SETTLE_CYCLES(2), .REPEAT(1), .ERR_W(8)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
   logic_gate_checker #(.SETTLE_CYCLES(1), .REPEAT(3), .ERR_W(8)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
   logic_gate_checker #(.SETTLE_CYCLES(1), .REPEAT(3), .ERR_W(3)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Truth-table arithmetic on 0/1 integers; bit order xnor..and, MSB first.
   function automatic logic [6:0] gold(input logic a, input logic b);
      int ia, ib, s;
      ia = a ? 1 : 0;
      ib = b ? 1 : 0;
      s  = ia + ib;
      return {s != 1, s == 1, s == 0, ia * ib == 0, ia == 0, s > 0, ia * ib == 1};
   endfunction

   function automatic logic [6:0] faulty(input logic [6:0] g, input logic [6:0] s0, input logic [6:0] fl);
      return (g & ~s0) ^ fl;
   endfunction

   assign if0.dut_out = faulty(gold(if0.a_o, if0.b_o), sa0[0], flip[0]);
   assign if1.dut_out = faulty(gold(if1.a_o, if1.b_o), sa0[1], flip[1]);
   assign if2.dut_out = faulty(gold(if2.a_o, if2.b_o), sa0[2], flip[2]);
   assign if0.start = st[0];
   assign if1.start = st[1];
   assign if2.start = st[2];

   assign obs_a[0] = if0.a_o;  assign obs_b[0] = if0.b_o;  assign obs_busy[0] = if0.busy;
   assign obs_a[1] = if1.a_o;  assign obs_b[1] = if1.b_o;  assign obs_busy[1] = if1.busy;
   assign obs_a[2] = if2.a_o;  assign obs_b[2] = if2.b_o;  assign obs_busy[2] = if2.busy;
   assign obs_done[0] = if0.done;  assign obs_pass[0] = if0.pass;  assign obs_mask[0] = if0.fail_mask;
   assign obs_done[1] = if1.done;  assign obs_pass[1] = if1.pass;  assign obs_mask[1] = if1.fail_mask;
   assign obs_done[2] = if2.done;  assign obs_pass[2] = if2.pass;  assign obs_mask[2] = if2.fail_mask;
   assign obs_err[0] = 32'(if0.err_count);
   assign obs_err[1] = 32'(if1.err_count);
   assign obs_err[2] = 32'(if2.err_count);

   function automatic int s_of(input int k); return (k == 0) ? 2 : 1; endfunction
   function automatic int r_of(input int k); return (k == 0) ? 1 : 3; endfunction
   function automatic int e_of(input int k); return (k == 2) ? 3 : 8; endfunction
   function automatic int exp_lat(input int k); return 4 * r_of(k) * (s_of(k) + 1) + 1; endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model(input int k, input logic [6:0] s0, input logic [6:0] fl,
                        output int e_err, output logic [6:0] e_mask, output int e_first);
      int bad, cap;
      logic [6:0] g, d;
      bad = 0; e_mask = '0; e_first = -1;
      for (int v = 0; v < 4; v++) begin
         g = gold(v >= 2, (v % 2) == 1);
         d = faulty(g, s0, fl) ^ g;
         if (d != 0) begin
            bad++;
            if (e_first < 0) e_first = v;
         end
         e_mask |= d;
      end
      e_err = bad * r_of(k);
      cap = (1 << e_of(k)) - 1;
      if (e_err > cap) e_err = cap;
   endtask

   task automatic check_idle_zero(input int k, input string tag);
      chk({tag, "_outs"}, 32'({obs_a[k], obs_b[k], obs_busy[k], obs_done[k], obs_pass[k], obs_mask[k]}), 32'd0);
      chk({tag, "_err"}, obs_err[k], 32'd0);
   endtask

   // Runs one start on instance k; lat = cycle done is seen, -1 if reset or timeout.
   task automatic run(input int k, input int restart_cyc, input bit pulse_in_done,
                      input int reset_cyc, output int lat);
      int c, v;
      lat = -1;
      @(negedge clk); st[k] = 1'b1;
      @(negedge clk); st[k] = 1'b0;
      c = 1;
      chk("cleared_on_start", 32'({obs_busy[k], obs_pass[k], obs_mask[k]}), 32'h100);
      chk("cleared_err", obs_err[k], 32'd0);
      while (c <= 300) begin
         if (c == reset_cyc) begin
            rst_n = 1'b0;
            #1;
            check_idle_zero(k, "async_reset");
            break;
         end
         if (obs_done[k]) begin
            lat = c;
            break;
         end
         v = ((c - 1) / (s_of(k) + 1)) % 4;
         chk("ab_vector", 32'({obs_a[k], obs_b[k]}), 32'(v));
         st[k] = (c == restart_cyc);
         @(negedge clk);
         c++;
      end
      st[k] = 1'b0;
      if (lat > 0) begin
         chk("ab_zero_in_done", 32'({obs_a[k], obs_b[k]}), 32'd0);
         if (pulse_in_done) st[k] = 1'b1;
         @(negedge clk);
         st[k] = 1'b0;
         chk("done_one_cycle", 32'({obs_done[k], obs_busy[k]}), 32'd0);
         repeat (3) @(negedge clk);
         chk("no_restart", 32'(obs_busy[k]), 32'd0);
      end
   endtask

   task automatic run_and_check(input int k, input int restart_cyc, input bit pulse_in_done,
                                input string tag);
      int lat, e_err, e_first;
      logic [6:0] e_mask;
      run(k, restart_cyc, pulse_in_done, -1, lat);
      model(k, sa0[k], flip[k], e_err, e_mask, e_first);
      chk({tag, "_latency"}, 32'(lat), 32'(exp_lat(k)));
      chk({tag, "_err_count"}, obs_err[k], 32'(e_err));
      chk({tag, "_fail_mask"}, 32'(obs_mask[k]), 32'(e_mask));
      chk({tag, "_pass"}, 32'(obs_pass[k]), 32'(e_err == 0));
`ifdef CHK_FIRST_FAIL_CAPTURE_EN
      if (k == 0) begin
         chk({tag, "_ff_valid"}, 32'(if0.first_fail_valid), 32'(e_first >= 0));
         if (e_first >= 0) begin
            chk({tag, "_ff_vec"}, 32'(if0.first_fail_vec), 32'(e_first));
            chk({tag, "_ff_sweep"}, 32'(if0.first_fail_sweep), 32'd0);
         end
      end
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, k;
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         st[i] = 1'b0; sa0[i] = '0; flip[i] = '0;
      end
      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) check_idle_zero(i, "reset");
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("idle_busy", 32'({obs_busy[0], obs_busy[1], obs_busy[2], obs_done[0]}), 32'd0);
      end

      run_and_check(0, -1, 1'b0, "good_default");

      sa0[0] = 7'b0100000;
      run_and_check(0, -1, 1'b0, "xor_sa0");

      flip[1] = 7'b0000100;
      run_and_check(1, -1, 1'b0, "not_inv_r3");
      flip[2] = 7'b0000100;
      run_and_check(2, -1, 1'b0, "not_inv_sat");

      run_and_check(0, 5, 1'b1, "restart_ignored");
      sa0[0] = '0;
      run_and_check(0, -1, 1'b0, "new_run_clears");

      run(0, -1, 1'b0, 7, lat);
      chk("reset_no_done_lat", 32'(lat), 32'hFFFF_FFFF);
      repeat (3) begin
         @(negedge clk);
         chk("reset_hold", 32'({obs_done[0], obs_busy[0], obs_a[0], obs_b[0]}), 32'd0);
      end
      rst_n = 1'b1;
      run_and_check(0, -1, 1'b0, "after_reset");

      for (int it = 0; it < 9; it++) begin
         k = int'($urandom_range(0, 2));
         sa0[k]  = 7'($urandom) & 7'($urandom);
         flip[k] = 7'($urandom) & 7'($urandom) & 7'($urandom);
         if ($urandom_range(0, 3) == 0) begin
            sa0[k] = '0; flip[k] = '0;
         end
         run_and_check(k, -1, 1'b0, "random");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
